char_string_plotter: RTL and testbench

- Sequential text renderer for the pixel framebuffer path: on start, walks every pixel cell of a string of up to MAX_CHARS glyphs from an internal font ROM and emits one plot request per pixel through a valid/ready handshake to the framebuffer writer.
- Successor to the per-letter combinational glyph decoders, generalised in string length, glyph pitch, coordinate/colour width, with draw/erase modes and back-pressure.

---
 rtl/char_string_plotter.sv | 208 ++++++++++++++++++++
 tb/tb_char_string_plotter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_string_plotter.sv
// rtl/char_string_plotter.sv - walks a glyph string and emits one plot request per pixel cell
module char_string_plotter #(
   parameter int MAX_CHARS  = 8,
   parameter int CHAR_PITCH = 8,
   parameter int COORD_W    = 8,
   parameter int COLOUR_W   = 6
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           start,
   input  logic                           erase,
   input  logic [COORD_W-1:0]             origin_x,
   input  logic [COORD_W-1:0]             origin_y,
   input  logic [5*MAX_CHARS-1:0]         text,
   input  logic [$clog2(MAX_CHARS+1)-1:0] num_chars,
   input  logic [COLOUR_W-1:0]            colour,
   input  logic                           plot_ready,
   output logic                           plot_valid,
   output logic [COORD_W-1:0]             plot_x,
   output logic [COORD_W-1:0]             plot_y,
   output logic [COLOUR_W-1:0]            plot_colour,
   output logic                           busy,
   output logic                           done
);

   localparam int NW = $clog2(MAX_CHARS + 1);
   localparam int CW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             col_q, col_d;
   logic [3:0]             row_q, row_d;
   logic [CW-1:0]          char_q, char_d;
   logic [NW-1:0]          num_q, num_d;
   logic                   erase_q, erase_d;
   logic [COORD_W-1:0]     ox_q, ox_d;
   logic [COORD_W-1:0]     oy_q, oy_d;
   logic [5*MAX_CHARS-1:0] text_q, text_d;
   logic [COLOUR_W-1:0]    colour_q, colour_d;

   logic [4:0]             codes [MAX_CHARS];
   logic [NW-1:0]          num_clamped;
   logic                   emit;
   logic                   advance;
   logic                   last_char;
   logic [COORD_W-1:0]     char_off;

   // Segment set per letter: [0]top [1]up-right [2]low-right [3]bottom [4]low-left [5]up-left
   // [6]middle [7]up-diag-left [8]up-centre [9]up-diag-right [10]low-diag-left [11]low-centre [12]low-diag-right
   function automatic logic [12:0] seg_mask(input logic [4:0] code);
      case (code)
         5'd0:    seg_mask = 13'h0077;
         5'd1:    seg_mask = 13'h094F;
         5'd2:    seg_mask = 13'h0039;
         5'd3:    seg_mask = 13'h090F;
         5'd4:    seg_mask = 13'h0079;
         5'd5:    seg_mask = 13'h0071;
         5'd6:    seg_mask = 13'h003D;
         5'd7:    seg_mask = 13'h0076;
         5'd8:    seg_mask = 13'h0909;
         5'd9:    seg_mask = 13'h001E;
         5'd10:   seg_mask = 13'h1270;
         5'd11:   seg_mask = 13'h0038;
         5'd12:   seg_mask = 13'h02B6;
         5'd13:   seg_mask = 13'h10B6;
         5'd14:   seg_mask = 13'h003F;
         5'd15:   seg_mask = 13'h0073;
         5'd16:   seg_mask = 13'h103F;
         5'd17:   seg_mask = 13'h1073;
         5'd18:   seg_mask = 13'h006D;
         5'd19:   seg_mask = 13'h0901;
         5'd20:   seg_mask = 13'h003E;
         5'd21:   seg_mask = 13'h1422;
         5'd22:   seg_mask = 13'h1436;
         5'd23:   seg_mask = 13'h1680;
         5'd24:   seg_mask = 13'h0A80;
         5'd25:   seg_mask = 13'h0609;
         default: seg_mask = 13'h0000;
      endcase
   endfunction

   // Font ROM lookup: strokes live in the 6x10 box at cols 2..7
   function automatic logic glyph_lit(input logic [4:0] code, input logic [3:0] row, input logic [2:0] col);
      logic [12:0] m;
      int r;
      int k;
      logic up;
      logic lo;
      m  = seg_mask(code);
      r  = int'(row);
      k  = int'(col) - 2;
      up = (r >= 1) && (r <= 3);
      lo = (r >= 5) && (r <= 8);
      if (k < 0) begin
         glyph_lit = 1'b0;
      end else begin
         glyph_lit = (m[0]  && r == 0) || (m[6] && r == 4) || (m[3] && r == 9) ||
                     (m[1]  && up && k == 5) || (m[2]  && lo && k == 5) ||
                     (m[5]  && up && k == 0) || (m[4]  && lo && k == 0) ||
                     (m[8]  && up && k == 2) || (m[11] && lo && k == 2) ||
                     (m[7]  && up && k == r) || (m[9]  && up && k == 5 - r) ||
                     (m[10] && lo && k == 8 - r) || (m[12] && lo && k == r - 3);
      end
   endfunction

   for (genvar g = 0; g < MAX_CHARS; g++) begin : g_codes
      assign codes[g] = text_q[5*g +: 5];
   end

   assign num_clamped = (num_chars > NW'(MAX_CHARS)) ? NW'(MAX_CHARS) : num_chars;
   assign last_char   = (NW'(char_q) + NW'(1)) == num_q;
   assign char_off    = COORD_W'(32'(char_q) * 32'(CHAR_PITCH));

   // Request outputs and advance strobe, derived only from registered state
   always_comb begin
      emit        = erase_q || glyph_lit(codes[char_q], row_q, col_q);
      plot_valid  = 1'b0;
      plot_x      = '0;
      plot_y      = '0;
      plot_colour = '0;
      busy        = (state_q == S_SCAN);
      done        = (state_q == S_DONE);
      advance     = (state_q == S_SCAN) && (!emit || plot_ready);
      if ((state_q == S_SCAN) && emit) begin
         plot_valid  = 1'b1;
         plot_x      = ox_q + char_off + COORD_W'(col_q);
         plot_y      = oy_q + COORD_W'(row_q);
         plot_colour = erase_q ? '0 : colour_q;
      end
   end

   // Next-state: latch the job on start, step col/row/char through the string
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      char_d   = char_q;
      num_d    = num_q;
      erase_d  = erase_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      text_d   = text_q;
      colour_d = colour_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               erase_d  = erase;
               ox_d     = origin_x;
               oy_d     = origin_y;
               text_d   = text;
               colour_d = colour;
               num_d    = num_clamped;
               col_d    = '0;
               row_d    = '0;
               char_d   = '0;
               state_d  = (num_clamped == '0) ? S_DONE : S_SCAN;
            end
         end
         S_SCAN: begin
            if (advance) begin
               if (col_q == 3'd7) begin
                  col_d = '0;
                  if (row_q == 4'd9) begin
                     row_d = '0;
                     if (last_char) state_d = S_DONE;
                     else           char_d  = char_q + CW'(1);
                  end else begin
                     row_d = row_q + 4'd1;
                  end
               end else begin
                  col_d = col_q + 3'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register with asynchronous clear
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         col_q    <= '0;
         row_q    <= '0;
         char_q   <= '0;
         num_q    <= '0;
         erase_q  <= 1'b0;
         ox_q     <= '0;
         oy_q     <= '0;
         text_q   <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         char_q   <= char_d;
         num_q    <= num_d;
         erase_q  <= erase_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         text_q   <= text_d;
         colour_q <= colour_d;
      end
   end

endmodule

// File: tb/tb_char_string_plotter.sv
// tb/tb_char_string_plotter.sv - randomized and directed check of char_string_plotter against a pixel-list model
module tb_char_string_plotter;
   localparam int MAXC  = 8;
   localparam int PITCH = 8;
   localparam int CWD   = 8;
   localparam int COLW  = 6;
   localparam int NWD   = $clog2(MAXC + 1);

   logic              clock = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic              erase = 1'b0;
   logic [CWD-1:0]    origin_x = '0;
   logic [CWD-1:0]    origin_y = '0;
   logic [5*MAXC-1:0] text = '0;
   logic [NWD-1:0]    num_chars = '0;
   logic [COLW-1:0]   colour = '0;
   logic              plot_ready = 1'b1;
   logic              plot_valid;
   logic [CWD-1:0]    plot_x;
   logic [CWD-1:0]    plot_y;
   logic [COLW-1:0]   plot_colour;
   logic              busy;
   logic              done;

   char_string_plotter #(.MAX_CHARS(MAXC), .CHAR_PITCH(PITCH), .COORD_W(CWD), .COLOUR_W(COLW)) dut (
      .clock(clock), .resetn(resetn), .start(start), .erase(erase),
      .origin_x(origin_x), .origin_y(origin_y), .text(text), .num_chars(num_chars),
      .colour(colour), .plot_ready(plot_ready), .plot_valid(plot_valid), .plot_x(plot_x),
      .plot_y(plot_y), .plot_colour(plot_colour), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int qx[$], qy[$], qc[$];
   int ax[$], ay[$], ac[$];
   int start_cyc = 0;
   int exp_n = 0;
   int stalls = 0;
   int done_cnt = 0;
   int last_rel = 0;
   bit prev_done = 0;
   int rmode = 0;
   int stall_left = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   function automatic bit model_lit(int code, int row, int col);
      if (code == 4) return (col >= 2) && (row == 0 || row == 4 || row == 9 || col == 2);
      return 0;
   endfunction

   task automatic model_load(input bit er, input int ox, input int oy, input logic [39:0] tx,
                             input int n, input int colr);
      int ne;
      int code;
      ne = (n > MAXC) ? MAXC : n;
      qx.delete(); qy.delete(); qc.delete();
      ax.delete(); ay.delete(); ac.delete();
      for (int ch = 0; ch < ne; ch++)
         for (int row = 0; row < 10; row++)
            for (int col = 0; col < 8; col++) begin
               code = int'((tx >> (5 * ch)) & 40'h1F);
               if (er || model_lit(code, row, col)) begin
                  qx.push_back((ox + ch * PITCH + col) % 256);
                  qy.push_back((oy + row) % 256);
                  qc.push_back(er ? 0 : colr);
               end
            end
      exp_n  = ne;
      stalls = 0;
   endtask

   task automatic do_start(input bit er, input int ox, input int oy, input logic [39:0] tx,
                           input int n, input int colr);
      @(posedge clock); #1;
      erase = er; origin_x = CWD'(ox); origin_y = CWD'(oy); text = tx;
      num_chars = NWD'(n); colour = COLW'(colr); start = 1'b1;
      model_load(er, ox, oy, tx, n, colr);
      done_cnt = 0;
      @(posedge clock); #1;
      start = 1'b0;
      start_cyc = cyc;
      erase = 1'($urandom); origin_x = CWD'($urandom); origin_y = CWD'($urandom);
      text = {$urandom, $urandom}; num_chars = NWD'($urandom); colour = COLW'($urandom);
   endtask

   task automatic wait_done(input int bound);
      int i;
      i = 0;
      while (done_cnt == 0 && i < bound) begin
         @(negedge clock);
         i++;
      end
      #1;
      chk("done_seen", done_cnt, 1);
   endtask

   // ready driver: 0 = always ready, 1 = random, 2 = low for stall_left cycles of a valid request
   initial forever begin
      @(posedge clock); #1;
      case (rmode)
         1: plot_ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (stall_left > 0 && plot_valid) begin
               plot_ready = 1'b0;
               stall_left--;
            end else begin
               plot_ready = 1'b1;
            end
         end
         default: plot_ready = 1'b1;
      endcase
   end

   // compare process: every request against the model's pixel list, done against its cycle
   initial forever begin
      @(negedge clock);
      if (resetn) begin
         if (plot_valid) begin
            if (qx.size() == 0) begin
               chk("spurious_plot", qx.size(), 1);
            end else begin
               chk("plot_x", plot_x, qx[0]);
               chk("plot_y", plot_y, qy[0]);
               chk("plot_colour", plot_colour, qc[0]);
               chk("busy_scan", busy, 1);
               if (plot_ready) begin
                  ax.push_back(int'(plot_x)); ay.push_back(int'(plot_y)); ac.push_back(int'(plot_colour));
                  void'(qx.pop_front()); void'(qy.pop_front()); void'(qc.pop_front());
               end else begin
                  stalls++;
               end
            end
         end
         if (done) begin
            last_rel = cyc - start_cyc + 1;
            chk("done_cycle", last_rel, 80 * exp_n + 1 + stalls);
            chk("done_left", qx.size(), 0);
            chk("done_busy", busy, 0);
            chk("done_valid", plot_valid, 0);
            chk("done_one_cycle", prev_done, 0);
            done_cnt++;
         end
         prev_done = done;
      end else begin
         prev_done = 0;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] tx;
      int n, r;
      bit er;

      #12;
      chk("rst_valid", plot_valid, 0);
      chk("rst_x", plot_x, 0);
      chk("rst_y", plot_y, 0);
      chk("rst_colour", plot_colour, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clock); #1;
      resetn = 1'b1;

      // single 'E'
      rmode = 0;
      do_start(0, 10, 20, 40'd4, 1, 6'h2A);
      wait_done(200);
      chk("e_count", ax.size(), 25);
      chk("e_first_x", ax[0], 12);
      chk("e_first_y", ay[0], 20);
      chk("e_last_x", ax[24], 17);
      chk("e_last_y", ay[24], 29);
      chk("e_colour", ac[0], 42);
      chk("e_done_cycle", last_rel, 81);

      // first request held 3 extra cycles
      rmode = 2; stall_left = 3;
      do_start(0, 10, 20, 40'd4, 1, 6'h2A);
      wait_done(200);
      chk("stall_count", ax.size(), 25);
      chk("stall_held", stalls, 3);
      chk("stall_done_cycle", last_rel, 84);
      rmode = 0;

      // "EE"
      do_start(0, 10, 20, (40'd4 << 5) | 40'd4, 2, 6'h2A);
      wait_done(300);
      chk("ee_count", ax.size(), 50);
      chk("ee_g1_x", ax[25], 20);
      chk("ee_g1_y", ay[25], 20);
      chk("ee_done_cycle", last_rel, 161);

      // blank in slot 1
      do_start(0, 10, 20, (40'd31 << 5) | 40'd4, 2, 6'h2A);
      wait_done(300);
      chk("blank_count", ax.size(), 25);
      chk("blank_done_cycle", last_rel, 161);

      // erase with wrap, start pulse during SCAN
      do_start(1, 250, 0, 40'd31, 1, 6'h15);
      repeat (20) @(posedge clock);
      #1; start = 1'b1; num_chars = NWD'(3); erase = 1'b0;
      @(posedge clock); #1; start = 1'b0;
      wait_done(200);
      chk("erase_count", ax.size(), 80);
      chk("erase_wrap6", ax[6], 0);
      chk("erase_wrap7", ax[7], 1);
      chk("erase_colour", ac[79], 0);
      chk("erase_done_cycle", last_rel, 81);

      // zero glyphs
      do_start(0, 10, 20, 40'd4, 0, 6'h2A);
      wait_done(20);
      chk("zero_count", ax.size(), 0);
      chk("zero_done_cycle", last_rel, 1);

      // over-long count clamps
      do_start(1, 3, 7, {$urandom, $urandom}, MAXC + 1, 6'h3F);
      wait_done(800);
      chk("clamp_count", ax.size(), 640);
      chk("clamp_done_cycle", last_rel, 641);

      // reset mid-string
      do_start(0, 10, 20, 40'd4, 1, 6'h2A);
      r = 0;
      while (!plot_valid && r < 100) begin
         @(negedge clock);
         r++;
      end
      chk("mid_valid_seen", plot_valid, 1);
      #2;
      resetn = 1'b0;
      qx.delete(); qy.delete(); qc.delete();
      #1;
      chk("mid_rst_valid", plot_valid, 0);
      chk("mid_rst_x", plot_x, 0);
      chk("mid_rst_y", plot_y, 0);
      chk("mid_rst_colour", plot_colour, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      chk("post_rst_idle", busy, 0);
      do_start(0, 10, 20, 40'd4, 1, 6'h2A);
      wait_done(200);
      chk("post_rst_count", ax.size(), 25);
      chk("post_rst_done_cycle", last_rel, 81);

      // randomized strings under random back-pressure
      rmode = 1;
      for (int it = 0; it < 25; it++) begin
         n  = $urandom_range(0, MAXC + 1);
         er = 1'($urandom);
         tx = '0;
         for (int i = 0; i < MAXC; i++) begin
            r = $urandom_range(0, 7);
            if (er)          tx[5*i +: 5] = 5'($urandom);
            else if (r < 2)  tx[5*i +: 5] = 5'd4;
            else             tx[5*i +: 5] = 5'(24 + r);
         end
         do_start(er, $urandom_range(0, 255), $urandom_range(0, 255), tx, n, $urandom_range(0, 63));
         wait_done(4000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
